// File: rtl/rob_multi_wb.sv
// rob_multi_wb: tag-addressed reorder buffer. It has NUM_WB writeback channels, a branch port that
// truncates the tail on a mispredict, and one in-order commit per cycle (commit_* are registered).
// Latency: a result written at edge E can retire at edge E+1.
// Backpressure: alloc_ready drops when the ROB is full or a mispredict resolves this cycle.
// Ports: clk/rst; alloc_* (entry request, returns alloc_tag); wb_* (NUM_WB result channels);
//        br_* (branch resolve/flush); commit_* (retired entry); count/empty/full (occupancy).
// Optional: define ROB_EXC_EN to add wb_exc/exc_valid/exc_pc. A retiring exception flushes the whole ROB.
module rob_multi_wb #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    parameter int NUM_WB = 3,
    // Derived from DEPTH; leave at its default.
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic                     alloc_reg_write,
    input  logic [4:0]               alloc_dest,
    input  logic [31:0]              alloc_pc,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_value,
`ifdef ROB_EXC_EN
    input  logic [NUM_WB-1:0]        wb_exc,
    output logic                     exc_valid,
    output logic [31:0]              exc_pc,
`endif
    input  logic                     br_valid,
    input  logic [TAG_W-1:0]         br_tag,
    input  logic                     br_mispredict,
    input  logic [DATA_W-1:0]        br_value,
    output logic                     commit_valid,
    output logic                     commit_reg_write,
    output logic [4:0]               commit_dest,
    output logic [DATA_W-1:0]        commit_value,
    output logic [31:0]              commit_pc,
    output logic [TAG_W:0]           count,
    output logic                     empty,
    output logic                     full
);
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    logic [DEPTH-1:0]  live_q, live_d, ready_q, ready_d, reg_write_q, reg_write_d;
    logic [4:0]        dest_q  [DEPTH];
    logic [4:0]        dest_d  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [31:0]       pc_q    [DEPTH];
    logic [31:0]       pc_d    [DEPTH];
    ptr_t              head_q, head_d, tail_q, tail_d;

    logic              commit_valid_q, commit_valid_d;
    logic              commit_reg_write_q, commit_reg_write_d;
    logic [4:0]        commit_dest_q, commit_dest_d;
    logic [DATA_W-1:0] commit_value_q, commit_value_d;
    logic [31:0]       commit_pc_q, commit_pc_d;

    tag_t head_idx, tail_idx, br_dist;
    logic do_flush, do_commit, alloc_fire, exc_commit;

    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    // Distance of the branch from head; wraps naturally in TAG_W bits.
    assign br_dist    = br_tag - head_idx;
    assign do_flush   = br_valid && br_mispredict && live_q[br_tag];
    assign do_commit  = live_q[head_idx] && ready_q[head_idx];

    assign count      = tail_q - head_q;
    assign empty      = (count == '0);
    assign full       = (count == DEPTH_P);
    // An exception retiring this edge wipes the tail, so an allocation then would be lost.
    assign alloc_ready = !full && !(br_valid && br_mispredict) && !exc_commit;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_idx;

`ifdef ROB_EXC_EN
    logic [DEPTH-1:0] exc_q, exc_d;
    logic             exc_valid_q, exc_valid_d;
    logic [31:0]      exc_pc_q, exc_pc_d;
    assign exc_commit = do_commit && exc_q[head_idx];
    assign exc_valid  = exc_valid_q;
    assign exc_pc     = exc_pc_q;
`else
    assign exc_commit = 1'b0;
`endif

    assign commit_valid     = commit_valid_q;
    assign commit_reg_write = commit_reg_write_q;
    assign commit_dest      = commit_dest_q;
    assign commit_value     = commit_value_q;
    assign commit_pc        = commit_pc_q;

    always_comb begin
        live_d             = live_q;
        ready_d            = ready_q;
        reg_write_d        = reg_write_q;
        dest_d             = dest_q;
        value_d            = value_q;
        pc_d               = pc_q;
        head_d             = head_q;
        tail_d             = tail_q;
        commit_valid_d     = 1'b0;
        commit_reg_write_d = commit_reg_write_q;
        commit_dest_d      = commit_dest_q;
        commit_value_d     = commit_value_q;
        commit_pc_d        = commit_pc_q;
`ifdef ROB_EXC_EN
        exc_d              = exc_q;
        exc_valid_d        = 1'b0;
        exc_pc_d           = exc_pc_q;
`endif
        // Ascending order: a higher channel hitting the same tag overwrites a lower one.
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && live_q[wb_tag[k*TAG_W +: TAG_W]]) begin
                ready_d[wb_tag[k*TAG_W +: TAG_W]] = 1'b1;
                value_d[wb_tag[k*TAG_W +: TAG_W]] = wb_value[k*DATA_W +: DATA_W];
`ifdef ROB_EXC_EN
                exc_d[wb_tag[k*TAG_W +: TAG_W]]   = wb_exc[k];
`endif
            end
        end
        // Branch result applied after the channels so it wins on a shared tag.
        if (br_valid && live_q[br_tag]) begin
            ready_d[br_tag] = 1'b1;
            value_d[br_tag] = br_value;
`ifdef ROB_EXC_EN
            exc_d[br_tag]   = 1'b0;
`endif
        end
        // Kill everything younger than the branch; slots beyond the old tail are already dead.
        if (do_flush) begin
            tail_d = head_q + ptr_t'(br_dist) + PTR_ONE;
            for (int i = 0; i < DEPTH; i++) begin
                if (tag_t'(tag_t'(i) - head_idx) > br_dist) begin
                    live_d[i]  = 1'b0;
                    ready_d[i] = 1'b0;
                end
            end
        end
        // Commit takes the pre-edge contents; same-cycle writes to the head are irrelevant.
        if (do_commit) begin
            commit_valid_d      = 1'b1;
            commit_reg_write_d  = reg_write_q[head_idx];
            commit_dest_d       = dest_q[head_idx];
            commit_value_d      = value_q[head_idx];
            commit_pc_d         = pc_q[head_idx];
            live_d[head_idx]    = 1'b0;
            ready_d[head_idx]   = 1'b0;
            head_d              = head_q + PTR_ONE;
        end
`ifdef ROB_EXC_EN
        if (exc_commit) begin
            commit_reg_write_d = 1'b0;
            exc_valid_d        = 1'b1;
            exc_pc_d           = pc_q[head_idx];
            live_d             = '0;
            ready_d            = '0;
            tail_d             = head_q + PTR_ONE;
        end
`endif
        // Never coincides with a flush (alloc_ready), and tail != head whenever head is live.
        if (alloc_fire) begin
            live_d[tail_idx]      = 1'b1;
            ready_d[tail_idx]     = 1'b0;
            reg_write_d[tail_idx] = alloc_reg_write;
            dest_d[tail_idx]      = alloc_dest;
            pc_d[tail_idx]        = alloc_pc;
`ifdef ROB_EXC_EN
            exc_d[tail_idx]       = 1'b0;
`endif
            tail_d                = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q             <= '0;
            tail_q             <= '0;
            live_q             <= '0;
            ready_q            <= '0;
            commit_valid_q     <= 1'b0;
            commit_reg_write_q <= 1'b0;
            commit_dest_q      <= '0;
            commit_value_q     <= '0;
            commit_pc_q        <= '0;
`ifdef ROB_EXC_EN
            exc_q              <= '0;
            exc_valid_q        <= 1'b0;
            exc_pc_q           <= '0;
`endif
        end else begin
            head_q             <= head_d;
            tail_q             <= tail_d;
            live_q             <= live_d;
            ready_q            <= ready_d;
            commit_valid_q     <= commit_valid_d;
            commit_reg_write_q <= commit_reg_write_d;
            commit_dest_q      <= commit_dest_d;
            commit_value_q     <= commit_value_d;
            commit_pc_q        <= commit_pc_d;
`ifdef ROB_EXC_EN
            exc_q              <= exc_d;
            exc_valid_q        <= exc_valid_d;
            exc_pc_q           <= exc_pc_d;
`endif
        end
    end

    // Payload is only meaningful while live, so it needs no reset.
    always_ff @(posedge clk) begin
        reg_write_q <= reg_write_d;
        dest_q      <= dest_d;
        value_q     <= value_d;
        pc_q        <= pc_d;
    end
endmodule

// File: doc/rob_multi_wb.md
Name: rob_multi_wb

Overview:
- Parametrised reorder buffer, next generation of the in-order commit ROB in the out-of-order core.
- Sits between decode/rename (allocation) and the architectural register file (commit).
- Entries are addressed by a returned tag instead of by PC match.
- Supports NUM_WB writeback channels, a branch-resolution port with tail-truncating flush, and one in-order commit per cycle with full/empty back-pressure.

Parameters:
DEPTH, 32, entry count; power of 2, >= 4
DATA_W, 32, result value width
NUM_WB, 3, writeback channels (ALU/MUL/DIV)
TAG_W, $clog2(DEPTH), entry tag width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
alloc_valid  in  1  decode requests an entry
alloc_ready  out  1  ROB can accept (combinational)
alloc_reg_write  in  1  instruction writes rd
alloc_dest  in  5  rd index
alloc_pc  in  32  instruction PC
alloc_tag  out  TAG_W  tag assigned to the accepted instruction (= tail index)
wb_valid  in  NUM_WB  per-channel result valid
wb_tag  in  NUM_WB*TAG_W  per-channel tag, channel k at [k*TAG_W +: TAG_W]
wb_value  in  NUM_WB*DATA_W  per-channel result
br_valid  in  1  branch resolved this cycle
br_tag  in  TAG_W  branch entry tag
br_mispredict  in  1  flush all entries younger than br_tag
br_value  in  DATA_W  link/return value written to the branch entry
commit_valid  out  1  one-cycle pulse, entry retired
commit_reg_write  out  1
commit_dest  out  5
commit_value  out  DATA_W
commit_pc  out  32
count  out  TAG_W+1  live entries
empty  out  1
full  out  1

Behaviour:
- Pointers head/tail are TAG_W+1 bits (wrap bit). count = tail - head; empty = (count == 0); full = (count == DEPTH).
- Entry fields: live, ready, reg_write, dest, value, pc.
- Reset: head = tail = 0, all live/ready = 0. commit_valid = 0, commit_reg_write = 0, commit_dest = 0, commit_value = 0, commit_pc = 0.
- Allocation:
  - alloc_ready = !full && !(br_valid && br_mispredict).
  - On alloc_valid && alloc_ready: entry[tail] <= {live = 1, ready = 0, fields}; tail += 1.
  - alloc_tag = tail[TAG_W-1:0] combinationally.
- Writeback:
  - For each k with wb_valid[k], if entry[wb_tag_k].live: set ready = 1 and value = wb_value_k.
  - Writeback to a non-live entry is ignored, including the entry being allocated in the same cycle.
  - Same tag on several channels in one cycle: highest k wins.
- Branch port:
  - br_valid to a live entry sets ready = 1 and value = br_value.
  - This takes priority over a wb channel writing the same tag in the same cycle.
- Mispredict (br_valid && br_mispredict && entry live):
  - d = (br_tag - head[TAG_W-1:0]) mod DEPTH; tail <= head + d + 1.
  - All entries with index in (br_tag, old tail) get live = ready = 0.
  - Writebacks targeting flushed entries in that same cycle are dropped.
  - Concurrent allocation is refused via alloc_ready.
- Commit:
  - At each edge, if entry[head] is live and ready: register its fields to commit_*, pulse commit_valid = 1, clear live/ready, head += 1.
  - Otherwise commit_valid = 0 and the other commit_* outputs hold their last value.
  - Entries with reg_write = 0 still commit, with commit_reg_write = 0.
- Latency: a writeback sampled at edge E retires at the earliest at edge E+1, so commit_valid is high in the cycle after E+1.
- Simultaneous events:
  - Commit and allocation in one cycle with full = 1: allocation is still refused (alloc_ready uses the registered full).
  - Commit and mispredict in one cycle: head advances and tail is computed from the pre-commit head. The count stays consistent.
- rst asserted mid-operation discards all entries on that edge; no commit pulse is generated.

Optional Feature:
ROB_EXC_EN:
- Adds input wb_exc [NUM_WB] and outputs exc_valid (1) and exc_pc (32). A per-entry exc bit is set together with ready.
- When the head entry retires with exc = 1:
  - commit_reg_write is forced to 0;
  - exc_valid pulses for one cycle with exc_pc = entry pc;
  - the whole ROB is flushed on that edge (tail <= head + 1 before the increment, all entries cleared).
- Without the macro: no ports, no exc storage, behaviour as above.

Test Plan:
- DEPTH = 8. Reset, allocate 3 instructions (PC 0x100/0x104/0x108) -> alloc_tag 0, 1, 2; count = 3; commit_valid stays 0.
- Writeback tag2 then tag0 then tag1 (values 0xA, 0xB, 0xC) -> commits in order PC 0x100/0x104/0x108 with values 0xB, 0xC, 0xA; empty = 1 afterwards.
- Fill all 8 entries -> full = 1, alloc_ready = 0. A 9th alloc_valid is not accepted. Retire head -> the next allocation receives tag 0 (wrap).
- Entries 0..5 live; br_valid, br_tag = 2, br_mispredict, br_value = 0x200 -> count = 3; wb to tag 4 in the same cycle is dropped; next alloc_tag = 3.
- wb_valid = 3'b011, both channels on tag 1 with values 0x11 and 0x22 -> entry 1 retires with value 0x22.
- ROB_EXC_EN: wb_exc on the head entry with PC 0x300 -> exc_valid = 1, exc_pc = 0x300, commit_reg_write = 0, count = 0 on the next cycle.
